// File: rtl/cart_loader_pkg.sv
// cart_loader_pkg: shared types and constants for the cartridge loader.
//   cl_state_t  - loader FSM states (also exported on the debug port)
//   ST2_MAGIC   - "RCA2" header magic, byte 0 in bits [31:24]
//   HDR_*       - ST2 header byte offsets
//   IDX_*       - ioctl_index file-type codes
// Optional feature macro used by the loader: CART_LOADER_CHKSUM_EN.
package cart_loader_pkg;

  typedef enum logic [2:0] {
    CL_IDLE = 3'd0,
    CL_RAW  = 3'd1,
    CL_HDR  = 3'd2,
    CL_DATA = 3'd3,
    CL_DONE = 3'd4,
    CL_ERR  = 3'd5
  } cl_state_t;

  localparam logic [31:0] ST2_MAGIC = 32'h5243_4132;

  localparam int HDR_BLKCNT = 4;
  localparam int HDR_PAGES  = 64;
  localparam int HDR_CHK    = 8;

  localparam logic [7:0] IDX_RAW = 8'd0;
  localparam logic [7:0] IDX_ST2 = 8'd1;

  // Expected header byte at offset 0..3.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ST2_MAGIC[31:24];
      2'd1:    b = ST2_MAGIC[23:16];
      2'd2:    b = ST2_MAGIC[15:8];
      default: b = ST2_MAGIC[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cart_loader_if.sv
// cart_loader_if: download stream in, cartridge RAM write port out.
//   ioctl_download/index/wr/addr/dout - hps_io download stream
//   mem_we/mem_addr/mem_din           - cartridge RAM single-cycle write
// Transfer rules: ioctl_wr is a one-cycle byte strobe that only counts while
// ioctl_download is high; there is no ready/backpressure, the loader must
// take every byte. mem_we is a one-cycle strobe; mem_addr/mem_din are valid
// only in a cycle where mem_we is high.
// modport master: the download host (drives ioctl_*, observes mem_*).
// modport slave : the loader (consumes ioctl_*, drives mem_*).
interface cart_loader_if #(
  parameter int ADDR_W = 12
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  mem_we, mem_addr, mem_din
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/cart_page_tbl.sv
// cart_page_tbl: MAX_BLOCKS x 8 page table for ST2 relocation.
//   clk, reset_n    - clock, async active-low reset (clears every entry)
//   we/waddr/wdata  - synchronous write port
//   raddr/rdata     - asynchronous read port (out-of-range reads return 0)
module cart_page_tbl #(
  parameter int MAX_BLOCKS = 64,
  parameter int AW         = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] tbl_q [MAX_BLOCKS];
  logic [7:0] tbl_d [MAX_BLOCKS];

  always_comb begin
    tbl_d = tbl_q;
    if (we && (int'(waddr) < MAX_BLOCKS)) tbl_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_BLOCKS; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  assign rdata = (int'(raddr) < MAX_BLOCKS) ? tbl_q[raddr] : '0;

endmodule

// File: rtl/cart_loader.sv
// cart_loader: converts an hps_io download (raw .bin or .st2) into writes on
// the 4 KB cartridge RAM and holds the console CPU in reset while loading.
//   clk, reset_n - system clock, async active-low reset
//   bus          - cart_loader_if.slave (ioctl stream in, RAM write out)
//   cpu_hold     - console reset request while a load is in progress
//   load_done    - sticky: last load finished cleanly
//   load_err     - sticky: last load failed
//   dbg_state    - current FSM state
//   chksum       - (CART_LOADER_CHKSUM_EN only) 16-bit sum of written bytes
// Macro CART_LOADER_CHKSUM_EN adds the checksum port and, for ST2 images,
// compares it against header bytes 8..9 at the end of the load.
module cart_loader
  import cart_loader_pkg::*;
#(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] RAW_BASE   = ADDR_W'(12'h400),
  parameter int                MAX_BLOCKS = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  cart_loader_if.slave       bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output cl_state_t          dbg_state
`ifdef CART_LOADER_CHKSUM_EN
  ,output logic [15:0]       chksum
`endif
);

  localparam int         PT_AW   = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [24:0] RAW_LIM = 25'((1 << ADDR_W) - int'(RAW_BASE));
  localparam logic [8:0]  PG_LO   = 9'(HDR_PAGES);
  localparam logic [8:0]  PG_HI   = 9'(HDR_PAGES + MAX_BLOCKS);
  localparam logic [8:0]  CNT_MAX = 9'(MAX_BLOCKS + 1);

  cl_state_t         state_q, state_d;
  logic              dl_q;
  logic              pend_q, pend_d;
  logic              bad_q, bad_d;
  logic [7:0]        blk_cnt_q, blk_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef CART_LOADER_CHKSUM_EN
  logic [15:0]       chk_q, chk_d;
  logic [15:0]       hdr_chk_q, hdr_chk_d;
  logic              fail;
`endif

  logic             rise, fall, wr_ok, start;
  logic [7:0]       off;
  logic [5:0]       blk_sel;
  logic             data_ok, in_pg;
  logic             pt_we;
  logic [PT_AW-1:0] pt_waddr, pt_raddr;
  logic [7:0]       pt_rdata;

  assign rise  = bus.ioctl_download & ~dl_q;
  assign fall  = ~bus.ioctl_download & dl_q;
  // A strobe coinciding with the falling edge still belongs to the image.
  assign wr_ok = bus.ioctl_wr & (bus.ioctl_download | dl_q);
  assign start = rise | (pend_q & bus.ioctl_download);

  assign off      = bus.ioctl_addr[7:0];
  assign blk_sel  = bus.ioctl_addr[13:8];
  assign pt_raddr = PT_AW'(blk_sel - 6'd1);
  assign pt_waddr = PT_AW'(off - 8'(HDR_PAGES));
  assign in_pg    = ({1'b0, off} >= PG_LO) && ({1'b0, off} < PG_HI);

  // Data block n (file page n+1) is valid if it exists in the header's
  // count and its relocation page lies inside the 4 KB window.
  assign data_ok = (bus.ioctl_addr[24:14] == '0) && (blk_sel != 6'd0) &&
                   ({2'b00, blk_sel} < blk_cnt_q) && (pt_rdata[7:4] == 4'd0);

  cart_page_tbl #(
    .MAX_BLOCKS (MAX_BLOCKS),
    .AW         (PT_AW)
  ) u_page_tbl (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (pt_we),
    .waddr   (pt_waddr),
    .wdata   (bus.ioctl_dout),
    .raddr   (pt_raddr),
    .rdata   (pt_rdata)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    bad_d      = bad_q;
    blk_cnt_d  = blk_cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    done_d     = done_q;
    err_d      = err_q;
    pt_we      = 1'b0;
`ifdef CART_LOADER_CHKSUM_EN
    chk_d      = chk_q;
    hdr_chk_d  = hdr_chk_q;
    fail       = 1'b0;
`endif

    case (state_q)
      CL_IDLE: begin
        pend_d = 1'b0;
        if (start && (bus.ioctl_index == IDX_RAW || bus.ioctl_index == IDX_ST2)) begin
          state_d   = (bus.ioctl_index == IDX_RAW) ? CL_RAW : CL_HDR;
          done_d    = 1'b0;
          err_d     = 1'b0;
          bad_d     = 1'b0;
          blk_cnt_d = '0;
`ifdef CART_LOADER_CHKSUM_EN
          chk_d     = '0;
          hdr_chk_d = '0;
`endif
        end
      end

      CL_RAW: begin
        if (wr_ok) begin
          if (bus.ioctl_addr >= RAW_LIM) begin
            bad_d = 1'b1;
          end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = RAW_BASE + bus.ioctl_addr[ADDR_W-1:0];
            mem_din_d  = bus.ioctl_dout;
`ifdef CART_LOADER_CHKSUM_EN
            chk_d      = chk_q + {8'd0, bus.ioctl_dout};
`endif
          end
        end
        if (fall) state_d = bad_d ? CL_ERR : CL_DONE;
      end

      CL_HDR: begin
        if (wr_ok && (bus.ioctl_addr[24:8] == '0)) begin
          if ((off[7:2] == 6'd0) && (bus.ioctl_dout != magic_byte(off[1:0])))
            bad_d = 1'b1;
          if (off == 8'(HDR_BLKCNT)) begin
            blk_cnt_d = bus.ioctl_dout;
            if ((bus.ioctl_dout == 8'd0) || ({1'b0, bus.ioctl_dout} > CNT_MAX))
              bad_d = 1'b1;
          end
`ifdef CART_LOADER_CHKSUM_EN
          if (off == 8'(HDR_CHK))     hdr_chk_d[7:0]  = bus.ioctl_dout;
          if (off == 8'(HDR_CHK + 1)) hdr_chk_d[15:8] = bus.ioctl_dout;
`endif
          if (in_pg) pt_we = 1'b1;
          if (off == 8'hFF) state_d = CL_DATA;
        end
        // Download ending anywhere inside the header is a truncated image.
        if (fall) state_d = CL_ERR;
      end

      CL_DATA: begin
        if (wr_ok) begin
          if (data_ok) begin
            mem_we_d   = 1'b1;
            mem_addr_d = ADDR_W'({pt_rdata[3:0], off});
            mem_din_d  = bus.ioctl_dout;
`ifdef CART_LOADER_CHKSUM_EN
            chk_d      = chk_q + {8'd0, bus.ioctl_dout};
`endif
          end else begin
            bad_d = 1'b1;
          end
        end
        if (fall) begin
`ifdef CART_LOADER_CHKSUM_EN
          fail    = bad_d | (chk_d != hdr_chk_q);
          state_d = fail ? CL_ERR : CL_DONE;
`else
          state_d = bad_d ? CL_ERR : CL_DONE;
`endif
        end
      end

      CL_DONE: begin
        done_d  = 1'b1;
        state_d = CL_IDLE;
        if (rise) pend_d = 1'b1;
      end

      CL_ERR: begin
        err_d   = 1'b1;
        state_d = CL_IDLE;
        if (rise) pend_d = 1'b1;
      end

      default: state_d = CL_IDLE;
    endcase

    cpu_hold_d = (state_d != CL_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CL_IDLE;
      // Reset to "download seen high": a window still open across reset
      // produces no rising edge and is ignored until it closes.
      dl_q       <= 1'b1;
      pend_q     <= 1'b0;
      bad_q      <= 1'b0;
      blk_cnt_q  <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CART_LOADER_CHKSUM_EN
      chk_q      <= '0;
      hdr_chk_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dl_q       <= bus.ioctl_download;
      pend_q     <= pend_d;
      bad_q      <= bad_d;
      blk_cnt_q  <= blk_cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef CART_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
      hdr_chk_q  <= hdr_chk_d;
`endif
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign dbg_state    = state_q;
`ifdef CART_LOADER_CHKSUM_EN
  assign chksum       = chk_q;
`endif

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: self-checking bench for cart_loader.
// Expected RAM writes {cycle, addr, data} are queued as bytes are driven and
// popped by a monitor on the falling clock edge.
module tb_cart_loader;
  import cart_loader_pkg::*;

  localparam int W = 52;

  logic      clk;
  logic      reset_n;
  logic      cpu_hold;
  logic      load_done;
  logic      load_err;
  cl_state_t dbg_state;
`ifdef CART_LOADER_CHKSUM_EN
  logic [15:0] chksum;
`endif

  cart_loader_if #(.ADDR_W(12)) bus ();

  cart_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .dbg_state (dbg_state)
`ifdef CART_LOADER_CHKSUM_EN
    ,.chksum   (chksum)
`endif
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           we_cnt   = 0;
  int           hold_drops = 0;
  bit           in_load  = 1'b0;
  logic [11:0]  last_addr = '0;
  logic [7:0]   hdr [256];
  logic [7:0]   dat [512];
  logic [15:0]  dsum;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: every RAM write must match the head of the expected queue,
  // including the cycle it appears in.
  always @(negedge clk) begin
    logic [W-1:0] got;
    if (reset_n && bus.mem_we) begin
      we_cnt++;
      last_addr = bus.mem_addr;
      got = {cyc[31:0], bus.mem_addr, bus.mem_din};
      if (exp_q.size() == 0) check("unexp_wr", 64'(got), 64'd0);
      else                   check("mem_wr", 64'(got), 64'(exp_q.pop_front()));
    end
    if (in_load && !cpu_hold) hold_drops++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    we_cnt = 0;
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    tick(2);
    in_load = (idx <= 8'd1);
  endtask

  task automatic end_dl();
    in_load = 1'b0;
    bus.ioctl_download = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input int a, input logic [7:0] d, input bit expw, input logic [11:0] ea);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    if (expw) exp_q.push_back({cyc[31:0] + 32'd1, ea, d});
    tick(1);
    bus.ioctl_wr = 1'b0;
    tick(1);
  endtask

  task automatic raw_load(input int n);
    start_dl(IDX_RAW);
    for (int i = 0; i < n; i++)
      send_byte(i, 8'(i), (i < 3072), 12'(32'h400 + i));
    end_dl();
  endtask

  task automatic build_hdr(input logic [7:0] m3);
    for (int j = 0; j < 256; j++) hdr[j] = 8'($urandom_range(0, 255));
    hdr[0] = 8'h52; hdr[1] = 8'h43; hdr[2] = 8'h41; hdr[3] = m3;
    hdr[4] = 8'd3;
    hdr[8] = dsum[7:0]; hdr[9] = dsum[15:8];
    hdr[64] = 8'h07; hdr[65] = 8'h04;
  endtask

  task automatic send_hdr(input int n);
    for (int j = 0; j < n; j++) send_byte(j, hdr[j], 1'b0, 12'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_mem_we",    bus.mem_we,   0);
    check("rst_mem_addr",  bus.mem_addr, 0);
    check("rst_mem_din",   bus.mem_din,  0);
    check("rst_cpu_hold",  cpu_hold,     0);
    check("rst_load_done", load_done,    0);
    check("rst_load_err",  load_err,     0);
    check("rst_state",     dbg_state,    CL_IDLE);
    tick(1);

    // Raw 1024 bytes, data = addr[7:0].
    raw_load(1024);
    check("raw_we_cnt",    we_cnt,     1024);
    check("raw_last_addr", last_addr,  12'h7FF);
    check("raw_hold",      hold_drops, 0);
    check("raw_done",      load_done,  1);
    check("raw_err",       load_err,   0);
    check("raw_hold_off",  cpu_hold,   0);

    // ST2: blk_cnt 3, pages {07,04}, 512 random data bytes.
    dsum = '0;
    for (int i = 0; i < 512; i++) begin
      dat[i] = 8'($urandom_range(0, 255));
      dsum   = dsum + {8'd0, dat[i]};
    end
    build_hdr(8'h32);
    start_dl(IDX_ST2);
    send_hdr(256);
    check("st2_hdr_no_wr", we_cnt, 0);
    for (int i = 0; i < 512; i++)
      send_byte(256 + i, dat[i], 1'b1, (i < 256) ? 12'(32'h700 + i) : 12'(32'h400 + i - 256));
    end_dl();
    check("st2_we_cnt", we_cnt,    512);
    check("st2_done",   load_done, 1);
    check("st2_err",    load_err,  0);
`ifdef CART_LOADER_CHKSUM_EN
    check("st2_chksum", chksum, dsum);
`endif

    // Bad magic "RCA1".
    build_hdr(8'h31);
    start_dl(IDX_ST2);
    send_hdr(256);
    end_dl();
    check("magic_err",   load_err,  1);
    check("magic_done",  load_done, 0);
    check("magic_we",    we_cnt,    0);

    // Raw 3073 bytes: last byte overflows the window.
    raw_load(3073);
    check("ovf_we_cnt",    we_cnt,    3072);
    check("ovf_last_addr", last_addr, 12'hFFF);
    check("ovf_err",       load_err,  1);
    check("ovf_done",      load_done, 0);

    // Truncated header.
    build_hdr(8'h32);
    start_dl(IDX_ST2);
    send_hdr(100);
    end_dl();
    check("trunc_err",   load_err,  1);
    check("trunc_done",  load_done, 0);
    check("trunc_we",    we_cnt,    0);
    check("trunc_state", dbg_state, CL_IDLE);

    // Async reset at byte 500 of a raw load.
    start_dl(IDX_RAW);
    for (int i = 0; i < 500; i++) send_byte(i, 8'(i), 1'b1, 12'(32'h400 + i));
    tick(1);
    in_load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("ar_mem_we",    bus.mem_we,   0);
    check("ar_mem_addr",  bus.mem_addr, 0);
    check("ar_mem_din",   bus.mem_din,  0);
    check("ar_cpu_hold",  cpu_hold,     0);
    check("ar_load_done", load_done,    0);
    check("ar_load_err",  load_err,     0);
    check("ar_state",     dbg_state,    CL_IDLE);
    #2 reset_n = 1'b1;
    tick(1);
    we_cnt = 0;
    for (int i = 500; i < 600; i++) send_byte(i, 8'(i), 1'b0, 12'h0);
    end_dl();
    check("ar_win_we",   we_cnt,    0);
    check("ar_win_done", load_done, 0);
    check("ar_win_err",  load_err,  0);
    raw_load(1024);
    check("ar_reload_we",   we_cnt,    1024);
    check("ar_reload_done", load_done, 1);
    check("ar_reload_err",  load_err,  0);

    // Unsupported index: ignored, flags untouched.
    start_dl(8'd2);
    for (int i = 0; i < 10; i++) send_byte(i, 8'(i), 1'b0, 12'h0);
    check("idx2_hold", cpu_hold, 0);
    end_dl();
    check("idx2_we",   we_cnt,    0);
    check("idx2_done", load_done, 1);
    check("idx2_err",  load_err,  0);

    check("hold_drops",  hold_drops,   0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Sits between the hps_io ioctl download stream and the rcastudioii cartridge memory.
- Accepts either raw binary images or ST2 container images and converts them into single-cycle writes on a 4 KB cartridge RAM port.
- For ST2 images, parses the 256-byte header and relocates each 256-byte data block to the page named in the header.
- Holds the console CPU in reset for the whole load and reports load status.

Parameters:
- ADDR_W, 12, cartridge RAM address width (4 KB window).
- RAW_BASE, 12'h400, load address of byte 0 of a raw image.
- MAX_BLOCKS, 64, maximum ST2 data blocks held in the page table.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  file type: 0 = raw .bin, 1 = .st2; other values are ignored.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  file byte.
- mem_we  out  1  cartridge RAM write strobe.
- mem_addr  out  ADDR_W  cartridge RAM address.
- mem_din  out  8  cartridge RAM write data.
- cpu_hold  out  1  console reset request while loading.
- load_done  out  1  last load completed without error (sticky).
- load_err  out  1  last load failed (sticky).

Interface decision (already decided): one clock, clk; reset is asynchronous and active-low, reset_n.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_din=0, cpu_hold=0, load_done=0, load_err=0, state=IDLE, page table cleared to 0.
- States: IDLE, RAW, HDR, DATA, DONE, ERR.
- IDLE:
  - On rising edge of ioctl_download with index 0, go to RAW; with index 1, go to HDR.
  - In both cases clear load_done/load_err.
  - Any other index stays in IDLE; writes are ignored.
- cpu_hold=1 in RAW, HDR and DATA, and for the first cycle of DONE/ERR; 0 otherwise.
- RAW:
  - Each ioctl_wr produces mem_we=1 on the next cycle, mem_addr = RAW_BASE + ioctl_addr[ADDR_W-1:0] (modulo 2^ADDR_W), mem_din = ioctl_dout.
  - Latency is one cycle, with no backpressure.
  - ioctl_addr >= 2^ADDR_W - RAW_BASE sets an overflow flag; that write is suppressed.
- HDR (ioctl_addr 0..255, no memory writes):
  - Bytes 0..3 must equal "RCA2" (0x52,0x43,0x41,0x32); otherwise set a magic-fail flag.
  - Byte 4 is blk_cnt, the total block count including the header.
  - blk_cnt = 0, or blk_cnt-1 > MAX_BLOCKS, sets a fail flag.
  - Bytes 64..64+MAX_BLOCKS-1 are stored in page_tbl[i] as the high page of data block i.
  - The write at ioctl_addr=255 moves the FSM to DATA.
- DATA:
  - block = ioctl_addr[13:8]-1 and off = ioctl_addr[7:0].
  - mem_addr = {page_tbl[block][3:0], off}, mem_we next cycle.
  - page_tbl[block][7:4] != 0, or block >= blk_cnt-1, suppresses the write and sets the overflow flag.
- Falling edge of ioctl_download:
  - From RAW or DATA, go to DONE if no flag is set, else ERR.
  - From HDR, always go to ERR (truncated header).
- DONE sets load_done=1; ERR sets load_err=1. Both return to IDLE on the next cycle. The flags stay set until the next load starts.
- Simultaneous ioctl_wr and falling ioctl_download: the byte is still written, then the terminal transition is taken.
- A new rising download edge while in DONE/ERR is honoured on the following IDLE cycle. The hps_io protocol guarantees a gap of at least 2 cycles, so no start is lost.
- ioctl_wr while ioctl_download=0 is ignored in all states.
- Async reset mid-load:
  - Aborts immediately; all outputs go to their reset values.
  - Partially written RAM is not scrubbed.
  - The FSM ignores the remainder of that window and waits for the next rising edge.

Optional Feature:
- Macro: CART_LOADER_CHKSUM_EN.
- When defined:
  - Adds output chksum[15:0]: a 16-bit modular sum of every byte actually written to RAM.
  - It is cleared on load start and valid when load_done rises.
  - For ST2 images, header bytes 8..9 (little-endian) are compared against it; a mismatch sets load_err instead of load_done.
- When undefined: no chksum port, no comparison.

Decomposition:
- Package cart_loader_pkg holds:
  - state enum cl_state_t;
  - ST2_MAGIC constant;
  - header offsets HDR_BLKCNT=4, HDR_PAGES=64, HDR_CHK=8;
  - index constants IDX_RAW=0, IDX_ST2=1.
- One sub-module, cart_page_tbl: a MAX_BLOCKS x 8 register file with a synchronous write port and an asynchronous read port, cleared on reset_n.

Test Plan:
- Raw load of 1024 bytes at index 0, data = addr[7:0]. Expect:
  - mem_we 1024 times at 0x400..0x7FF, each one cycle after ioctl_wr;
  - cpu_hold high throughout;
  - load_done=1, load_err=0.
- ST2 with blk_cnt=3 and page table {0x07,0x04}, then 512 data bytes. Expect:
  - bytes 256..511 written to 0x700..0x7FF;
  - bytes 512..767 written to 0x400..0x4FF;
  - no writes during the header;
  - load_done=1.
- ST2 with magic "RCA1". Expect load_err=1 and load_done=0 after the download ends.
- Raw load of 3073 bytes. Expect:
  - 3072 writes ending at 0xFFF;
  - the 3073rd write suppressed;
  - load_err=1.
- Download dropped after 100 bytes at index 1 (header truncated). Expect ERR, load_err=1, zero mem_we pulses.
- reset_n pulsed low at byte 500 of a raw load, with download still high. Expect:
  - outputs go to their reset values immediately;
  - no further mem_we in that window;
  - the next full raw load gives load_done=1.
